// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiplier; divides stay iterative.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [2:0]          f3_q, f3_d;
  logic                negq_q, negq_d;
  logic                negr_q, negr_d;
  logic [XLEN-1:0]     out_q, out_d;
  logic                illegal_q, illegal_d;

  // Accept-side decode: which operands are signed, and their magnitudes
  logic            sgn1, sgn2, neg1, neg2, legal, div_zero, div_ovf;
  logic [XLEN-1:0] mag1, mag2;

  assign sgn1     = ~funct3[0] | (funct3 == 3'b001);
  assign sgn2     = (funct3[2] & ~funct3[0]) | (funct3[2:1] == 2'b00);
  assign neg1     = sgn1 & operand1[XLEN-1];
  assign neg2     = sgn2 & operand2[XLEN-1];
  assign mag1     = neg1 ? -operand1 : operand1;
  assign mag2     = neg2 ? -operand2 : operand2;
  assign legal    = (funct7 == 7'b0000001);
  assign div_zero = (operand2 == '0);
  assign div_ovf  = funct3[2] & ~funct3[0] & (operand1 == INT_MIN) & (operand2 == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod, fast_prod_fix;
  logic [XLEN-1:0]   fast_res;

  assign fast_prod     = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
  assign fast_prod_fix = (neg1 ^ neg2) ? -fast_prod : fast_prod;
  assign fast_res      = (funct3[1:0] == 2'b00) ? fast_prod_fix[XLEN-1:0]
                                                : fast_prod_fix[2*XLEN-1:XLEN];
`endif

  // acc_q holds {product_hi, multiplier} for multiply or {remainder, quotient} for divide
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, iter_acc;

  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : {XLEN{1'b0}})};
  assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  assign iter_acc  = f3_q[2] ? div_next : mul_next;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, calc_res;

  assign prod_fix = negq_q ? -iter_acc : iter_acc;
  assign quo_fix  = negq_q ? -iter_acc[XLEN-1:0] : iter_acc[XLEN-1:0];
  assign rem_fix  = negr_q ? -iter_acc[2*XLEN-1:XLEN] : iter_acc[2*XLEN-1:XLEN];

  always_comb begin
    calc_res = prod_fix[2*XLEN-1:XLEN];
    if (f3_q[2]) begin
      calc_res = f3_q[1] ? rem_fix : quo_fix;
    end else if (f3_q[1:0] == 2'b00) begin
      calc_res = prod_fix[XLEN-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    f3_d      = f3_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    out_d     = out_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          f3_d      = funct3;
          negq_d    = neg1 ^ neg2;
          negr_d    = neg1;
          cnt_d     = '0;
          opb_d     = mag2;
          acc_d     = {{XLEN{1'b0}}, mag1};
          illegal_d = 1'b0;
          state_d   = S_CALC;
          if (!legal) begin
            out_d     = '0;
            illegal_d = 1'b1;
            state_d   = S_DONE;
          end else if (funct3[2] && div_zero) begin
            out_d   = funct3[1] ? operand1 : '1;
            state_d = S_DONE;
          end else if (div_ovf) begin
            out_d   = funct3[1] ? '0 : operand1;
            state_d = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!funct3[2]) begin
            out_d   = fast_res;
            state_d = S_DONE;
`endif
          end
        end
      end
      S_CALC: begin
        acc_d = iter_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          out_d   = calc_res;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      f3_q      <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      out_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      f3_q      <= f3_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      out_q     <= out_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed-vector bench for muldiv_unit (XLEN=32)
module tb_muldiv_unit;

  localparam logic [6:0] F7_M = 7'b0000001;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        illegal;

  int checks;
  int errors;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand1  (operand1),
    .operand2  (operand2),
    .funct7    (funct7),
    .funct3    (funct3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op, measure latency, optionally stall in DONE, then consume.
  task automatic run_op(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                        input logic exp_ill, input int exp_lat, input int hold);
    int   lat;
    logic rdy_seen;
    check({tag, "_in_ready_idle"}, 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    funct7   = f7;
    funct3   = f3;
    operand1 = a;
    operand2 = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    operand1 = 32'hDEAD_BEEF;
    operand2 = 32'h1234_5678;
    funct3   = 3'b111;
    lat      = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      rdy_seen |= in_ready;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_out"}, 64'(out), 64'(exp));
    check({tag, "_illegal"}, 64'(illegal), 64'(exp_ill));
    check({tag, "_in_ready_busy"}, 64'(rdy_seen | in_ready), 64'(0));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_out"}, 64'(out), 64'(exp));
      check({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
      check({tag, "_hold_in_ready"}, 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_consumed_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_consumed_in_ready"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    int   seen;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    operand1  = '0;
    operand2  = '0;
    funct7    = F7_M;
    funct3    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_out", 64'(out), 64'(0));
    check("reset_illegal", 64'(illegal), 64'(0));

    run_op("mul_7x6",      F7_M, 3'b000, 32'd7,          32'd6,          32'd42,         1'b0, MUL_LAT, 0);
    run_op("mulh_min",     F7_M, 3'b001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  1'b0, MUL_LAT, 0);
    run_op("mulhu_max",    F7_M, 3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0, MUL_LAT, 0);
    run_op("mulhsu_m1",    F7_M, 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, MUL_LAT, 0);
    run_op("mul_neg",      F7_M, 3'b000, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  1'b0, MUL_LAT, 0);
    run_op("div_m7_2",     F7_M, 3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 33,      0);
    run_op("rem_m7_2",     F7_M, 3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, 33,      0);
    run_op("divu_max_2",   F7_M, 3'b101, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  1'b0, 33,      0);
    run_op("remu_10_3",    F7_M, 3'b111, 32'd10,         32'd3,          32'd1,          1'b0, 33,      0);
    run_op("div_by_zero",  F7_M, 3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b0, 1,       0);
    run_op("rem_by_zero",  F7_M, 3'b110, 32'd5,          32'd0,          32'd5,          1'b0, 1,       0);
    run_op("div_ovf",      F7_M, 3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1,       0);
    run_op("rem_ovf",      F7_M, 3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, 1,       0);
    run_op("illegal_f7",   7'b0100000, 3'b000, 32'd7,    32'd6,          32'd0,          1'b1, 1,       0);
    run_op("divu_backpr",  F7_M, 3'b101, 32'd100,        32'd7,          32'd14,         1'b0, 33,      5);
    run_op("mul_3x3",      F7_M, 3'b000, 32'd3,          32'd3,          32'd9,          1'b0, MUL_LAT, 0);

    // Reset ten cycles into a divide: the operation must vanish without a result
    in_valid = 1'b1;
    funct7   = F7_M;
    funct3   = 3'b100;
    operand1 = 32'd1000;
    operand2 = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midreset_out_valid", 64'(out_valid), 64'(0));
    check("midreset_in_ready", 64'(in_ready), 64'(1));
    check("midreset_out", 64'(out), 64'(0));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("midreset_no_result", 64'(seen), 64'(0));
    run_op("after_reset_remu", F7_M, 3'b111, 32'd10, 32'd3, 32'd1, 1'b0, 33, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle RV32M/RV64M multiply/divide unit; sits beside the single-cycle ALU in the execute stage.
- Selected by funct7 = 0000001; funct3 picks the operation.
- Iterative shift-add multiplier and restoring divider, one bit per cycle.
- valid/ready handshake on input and output, so the pipeline can stall on it.

Parameters:
- XLEN, 32, operand and result width (32 or 64).
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept (high only in IDLE).
- operand1  in  XLEN  rs1 value: multiplicand / dividend.
- operand2  in  XLEN  rs2 value: multiplier / divisor.
- funct7  in  7  must be 0000001.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out  out  XLEN  result.
- illegal  out  1  qualified by out_valid; funct7 was not 0000001.

Behaviour:
- Reset: sampled only at rising clk edge with rst_n=0.
  - state to IDLE; out_valid=0, out=0, illegal=0, in_ready=1; counter and internal registers 0.
  - Reset during CALC or DONE discards the in-flight operation with no output.
- FSM: IDLE -> CALC -> DONE -> IDLE; fast path IDLE -> DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge (accept), capture operand1, operand2, funct3, funct7.
  - Inputs are ignored after the accept edge until back in IDLE.
- Fast path (accept edge goes directly to DONE; out_valid high the cycle after accept):
  - funct7 != 0000001: out=0, illegal=1.
  - Divide by zero (operand2=0): DIV/DIVU out = all ones; REM/REMU out = operand1.
  - Signed overflow (DIV/REM, operand1 = 1<<(XLEN-1), operand2 = all ones): DIV out = operand1; REM out = 0.
- CALC:
  - Signed operands (MUL/MULH/DIV/REM both; MULHSU operand1 only) are converted to magnitudes at accept.
  - Exactly XLEN iterations, one per cycle. Multiply accumulates a 2*XLEN product; divide is restoring, MSB first.
  - After the XLEN-th iteration, apply sign fixup:
    - product negated if sign(op1) XOR sign(op2), with only signed operands counted;
    - quotient negated if signs differ;
    - remainder takes the dividend's sign.
  - Then enter DONE.
  - Latency: accept in cycle N -> out_valid first high in cycle N+XLEN+1.
- Result selection:
  - MUL = low XLEN of product; MULH/MULHSU/MULHU = high XLEN.
  - DIV/DIVU = quotient; REM/REMU = remainder.
- DONE:
  - out_valid=1; out and illegal held stable while out_ready=0.
  - On out_ready=1 at an edge -> IDLE; out_valid falls the next cycle.
- No overlap: a new op is never accepted in the cycle its predecessor's result is consumed. Minimum initiation interval is 2 cycles (fast path) or XLEN+2 cycles (iterative).
- in_ready is combinational from state only; no combinational path from in_valid or out_ready to any output.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - All four multiply ops use a single-cycle combinational 2*XLEN multiplier and take the fast path (out_valid in cycle N+1).
  - Divides remain iterative.
- Undefined: multiplies iterate as described (XLEN+1 latency); no hardware multiplier is inferred.

Test Plan (XLEN=32, feature undefined unless stated):
- MUL 7, 6 -> out=42, out_valid first high 33 cycles after accept; in_ready=0 throughout.
- MULH 0x80000000, 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF, 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF, 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7), 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 0xFFFFFFFF, 2 -> 0x7FFFFFFF; REMU 10, 3 -> 1.
- Fast path, each with out_valid in cycle N+1:
  - DIV 5, 0 -> 0xFFFFFFFF; REM 5, 0 -> 5.
  - DIV 0x80000000, 0xFFFFFFFF -> 0x80000000; REM same -> 0.
  - funct7=0100000 -> out=0, illegal=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out stable and in_ready=0. Then out_ready=1 -> IDLE next cycle; a new MUL 3, 3 accepted afterwards returns 9.
- Reset: rst_n=0 for one edge 10 cycles into a DIV -> next cycle out_valid=0, in_ready=1, out=0; no result emitted. With MULDIV_FAST_MUL_EN defined, MUL 7, 6 -> 42 in cycle N+1.
